// File: rtl/mem_xfer_pkg.sv
// Shared constants and FSM encoding for the memory transfer source side.
package mem_xfer_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 8;
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mem_stream_buf.sv
// Frame buffer: DEPTH x DATA_WIDTH register file, synchronous write, combinational read.
module mem_stream_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // No reset: contents survive a mid-frame reset and are reloaded by the host.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mem_stream_tx.sv
// Streams the 8-entry buffer one byte per clock with Hold stall and frame sequencing.
module mem_stream_tx #(
    parameter int DATA_WIDTH = mem_xfer_pkg::DATA_WIDTH,
    parameter int DEPTH      = mem_xfer_pkg::DEPTH,
    parameter int ADDR_WIDTH = mem_xfer_pkg::ADDR_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  WrEn,
    input  logic [ADDR_WIDTH-1:0] WrAddr,
    input  logic [DATA_WIDTH-1:0] WrData,
    input  logic                  Start,
    input  logic                  Hold,
    output logic [DATA_WIDTH-1:0] DataOutA,
    output logic                  ValidA,
    output logic                  LastA,
    output logic                  Busy,
    output logic                  FrameDone,
    output logic                  WrErr
);
    import mem_xfer_pkg::*;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_we, w_adv, w_last;

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid, r_last, r_busy, r_fdone, r_wrerr;

    // Host writes land only while idle; any write during a frame is dropped.
    assign w_we   = WrEn && (r_state == IDLE);
    assign w_adv  = (r_state == SEND) && !Hold;
    assign w_last = (r_ptr == ADDR_WIDTH'(DEPTH - 1));

    mem_stream_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_buf (
        .i_clk  (Clk),
        .i_we   (w_we),
        .i_waddr(WrAddr),
        .i_wdata(WrData),
        .i_raddr(r_ptr),
        .o_rdata(w_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (Start) w_state_nxt = SEND;
            SEND:    if (w_adv && w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = Start ? SEND : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && Start) r_ptr <= '0;
            else if (w_adv)               r_ptr <= r_ptr + ADDR_WIDTH'(1);
        end
    end

    // Outputs trail the FSM by one edge, so DONE shows up the cycle after LastA.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_fdone <= 1'b0;
            r_wrerr <= 1'b0;
        end else begin
            r_data  <= w_adv ? w_rdata : '0;
            r_valid <= w_adv;
            r_last  <= w_adv && w_last;
            r_busy  <= (r_state != IDLE);
            r_fdone <= (r_state == DONE);
            r_wrerr <= WrEn && (r_state != IDLE);
        end
    end

    assign DataOutA  = r_data;
    assign ValidA    = r_valid;
    assign LastA     = r_last;
    assign Busy      = r_busy;
    assign FrameDone = r_fdone;
    assign WrErr     = r_wrerr;
endmodule

// File: tb/tb_mem_stream_tx.sv
// Self-checking bench for mem_stream_tx: expected streams built from frame rules and a buffer image.
module tb_mem_stream_tx;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       WrEn = 1'b0, Start = 1'b0, Hold = 1'b0;
    logic [2:0] WrAddr = '0;
    logic [7:0] WrData = '0;
    logic [7:0] DataOutA;
    logic       ValidA, LastA, Busy, FrameDone, WrErr;

    int         vectors = 0;
    int         errors  = 0;
    logic [7:0] mbuf [8];

    always #5 Clk = ~Clk;

    mem_stream_tx dut (
        .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .Start(Start), .Hold(Hold), .DataOutA(DataOutA), .ValidA(ValidA),
        .LastA(LastA), .Busy(Busy), .FrameDone(FrameDone), .WrErr(WrErr)
    );

    // Packed view {valid,last,busy,framedone,wrerr,data}
    function automatic logic [12:0] obs();
        return {ValidA, LastA, Busy, FrameDone, WrErr, DataOutA};
    endfunction

    function automatic logic [12:0] ex(logic v, logic l, logic b, logic f, logic w, logic [7:0] d);
        return {v, l, b, f, w, d};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        #1 Reset = 1'b0;
        #2;
        if (obs() !== 13'd0) begin
            errors++; $display("FAIL reset_async got %b want %b", obs(), 13'd0);
        end
        vectors++;
        Start = 1'b1;
        repeat (2) tick();
        if (obs() !== 13'd0) begin
            errors++; $display("FAIL reset_held got %b want %b", obs(), 13'd0);
        end
        vectors++;
        @(negedge Clk) Reset = 1'b1; Start = 1'b0;
        tick();
        if (obs() !== 13'd0) begin
            errors++; $display("FAIL reset_release got %b want %b", obs(), 13'd0);
        end
        vectors++;
    endtask

    task automatic test_load(input logic [7:0] v [8]);
        for (int i = 0; i < 8; i++) begin
            WrEn = 1'b1; WrAddr = 3'(i); WrData = v[i];
            tick();
            mbuf[i] = v[i];
            if (obs() !== 13'd0) begin
                errors++; $display("FAIL load[%0d] got %b want %b", i, obs(), 13'd0);
            end
            vectors++;
        end
        WrEn = 1'b0;
    endtask

    // wr_edge: -1 none, 0 same edge as Start (accepted), 1..9 during the frame (dropped).
    task automatic test_frame(input string name, input int holds [8], input int wr_edge,
                              input logic [2:0] wa, input logic [7:0] wd);
        int e;
        logic [12:0] want;
        Start = 1'b1; WrEn = (wr_edge == 0); WrAddr = wa; WrData = wd;
        tick();
        if (wr_edge == 0) mbuf[wa] = wd;
        if (obs() !== 13'd0) begin
            errors++; $display("FAIL %s start got %b want %b", name, obs(), 13'd0);
        end
        vectors++;
        Start = 1'b0;
        e = 1;
        for (int i = 0; i < 8; i++) begin
            for (int h = 0; h <= holds[i]; h++) begin
                Hold = (h < holds[i]);
                WrEn = (e == wr_edge);
                tick();
                want = Hold ? ex(0, 0, 1, 0, e == wr_edge, 8'd0)
                            : ex(1, i == 7, 1, 0, e == wr_edge, mbuf[i]);
                if (obs() !== want) begin
                    errors++; $display("FAIL %s byte%0d edge%0d got %b want %b", name, i, e, obs(), want);
                end
                vectors++;
                e++;
            end
        end
        Hold = 1'($urandom_range(0, 1));
        WrEn = (e == wr_edge);
        tick();
        want = ex(0, 0, 1, 1, e == wr_edge, 8'd0);
        if (obs() !== want) begin
            errors++; $display("FAIL %s done got %b want %b", name, obs(), want);
        end
        vectors++;
        Hold = 1'($urandom_range(0, 1));
        WrEn = 1'b0;
        tick();
        if (obs() !== 13'd0) begin
            errors++; $display("FAIL %s idle got %b want %b", name, obs(), 13'd0);
        end
        vectors++;
        Hold = 1'b0;
    endtask

    task automatic test_back_to_back(input int nframes);
        logic [12:0] want;
        Start = 1'b1;
        tick();
        if (obs() !== 13'd0) begin
            errors++; $display("FAIL b2b_start got %b want %b", obs(), 13'd0);
        end
        vectors++;
        for (int f = 0; f < nframes; f++) begin
            for (int i = 0; i < 8; i++) begin
                tick();
                want = ex(1, i == 7, 1, 0, 0, mbuf[i]);
                if (obs() !== want) begin
                    errors++; $display("FAIL b2b f%0d byte%0d got %b want %b", f, i, obs(), want);
                end
                vectors++;
            end
            Start = (f < nframes - 1);
            tick();
            want = ex(0, 0, 1, 1, 0, 8'd0);
            if (obs() !== want) begin
                errors++; $display("FAIL b2b f%0d gap got %b want %b", f, obs(), want);
            end
            vectors++;
        end
        tick();
        if (obs() !== 13'd0) begin
            errors++; $display("FAIL b2b_idle got %b want %b", obs(), 13'd0);
        end
        vectors++;
    endtask

    task automatic test_reset_mid();
        logic [12:0] want;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            want = ex(1, 0, 1, 0, 0, mbuf[i]);
            if (obs() !== want) begin
                errors++; $display("FAIL rstmid byte%0d got %b want %b", i, obs(), want);
            end
            vectors++;
        end
        #2 Reset = 1'b0;
        #1;
        if (obs() !== 13'd0) begin
            errors++; $display("FAIL rstmid_async got %b want %b", obs(), 13'd0);
        end
        vectors++;
        Start = 1'b1;
        tick();
        @(negedge Clk) Reset = 1'b1; Start = 1'b0;
        tick();
        if (obs() !== 13'd0) begin
            errors++; $display("FAIL rstmid_idle got %b want %b", obs(), 13'd0);
        end
        vectors++;
    endtask

    task automatic test_random(input int iters);
        int         holds [8];
        logic [7:0] v;
        logic [2:0] a;
        int         we;
        for (int it = 0; it < iters; it++) begin
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                a = 3'($urandom); v = 8'($urandom);
                WrEn = 1'b1; WrAddr = a; WrData = v;
                tick();
                mbuf[a] = v;
                if (obs() !== 13'd0) begin
                    errors++; $display("FAIL rand_load it%0d got %b want %b", it, obs(), 13'd0);
                end
                vectors++;
            end
            WrEn = 1'b0;
            foreach (holds[i]) holds[i] = int'($urandom_range(0, 2));
            we = int'($urandom_range(0, 10)) - 1;
            test_frame("rand_frame", holds, we, 3'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        int         zeros [8];
        int         h3 [8];
        logic [7:0] spec_bytes [8];
        zeros      = '{default: 0};
        h3         = '{default: 0};
        h3[3]      = 2;
        spec_bytes = '{8'd37, 8'd20, 8'd57, 8'd142, 8'd119, 8'd84, 8'd231, 8'd7};

        test_reset();
        test_load(spec_bytes);
        test_frame("frame_basic", zeros, -1, 3'd0, 8'd0);
        test_frame("frame_hold", h3, -1, 3'd0, 8'd0);
        test_back_to_back(3);
        test_frame("frame_wrerr", zeros, 3, 3'd2, 8'd99);
        test_frame("frame_wrerr_done", zeros, 9, 3'd2, 8'd99);
        test_frame("frame_after_wrerr", zeros, -1, 3'd0, 8'd0);
        test_reset_mid();
        test_frame("frame_restart", zeros, -1, 3'd0, 8'd0);
        test_frame("frame_same_cycle", zeros, 0, 3'd0, 8'd200);
        test_random(8);
        test_back_to_back(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
